// File: rtl/flac_enc_pkg.sv
// Shared definitions for the FLAC encoder residual path: sizes, bank-state and
// drain-sequencer encodings.
package flac_enc_pkg;

    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int DW    = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        DRN_IDLE  = 2'd0,
        DRN_START = 2'd1,
        DRN_DRAIN = 2'd2
    } drain_state_t;

    function automatic logic [1:0] bank_mask(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bank_state_tracker.sv
// Life-cycle tracker for one ResidualBuffer bank: state, fill count and the
// length latched when the block closes.
module bank_state_tracker
    import flac_enc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write,
    input  logic          close,
    input  logic          start,
    input  logic          done,
    output bank_state_t   state,
    output logic [CW-1:0] count,
    output logic [CW-1:0] len
);

    // write/close only reach an EMPTY/FILLING bank, start only a FULL one and
    // done only a DRAINING one, so the strobes never compete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BANK_EMPTY;
            count <= '0;
            len   <= '0;
        end else if (write) begin
            if (close) begin
                len   <= count + 1'b1;
                count <= '0;
                state <= BANK_FULL;
            end else begin
                count <= count + 1'b1;
                state <= BANK_FILLING;
            end
        end else if (start) begin
            state <= BANK_DRAINING;
        end else if (done) begin
            state <= BANK_EMPTY;
        end
    end

endmodule

// File: rtl/residual_buffer_ctrl.sv
// Ping-pong scheduler between the LPC residual generator and the Rice encoder:
// fills one bank while the other is drained as a framed block.
module residual_buffer_ctrl
    import flac_enc_pkg::*;
(
    input  logic          iClock,
    input  logic          iReset,
    input  logic          iValid,
    input  logic [DW-1:0] iResidual,
    input  logic          iLast,
    output logic          oReady,
    output logic [1:0]    oBufValid,
    output logic [DW-1:0] oBufResidual,
    output logic [1:0]    oBufEnable,
    input  logic [DW-1:0] iBufResidual0,
    input  logic [DW-1:0] iBufResidual1,
    input  logic          iBufValid0,
    input  logic          iBufValid1,
    input  logic [CW-1:0] iBufCount0,
    input  logic [CW-1:0] iBufCount1,
    input  logic          iDownReady,
    output logic [DW-1:0] oResidual,
    output logic          oValid,
    output logic          oBlockStart,
    output logic [CW-1:0] oBlockLen,
    output logic          oBlockDone,
    output logic          oOverflow,
    output logic          oError,
    output logic [1:0]    oDrainState
);

    bank_state_t   bank_state [2];
    logic [CW-1:0] bank_count [2];
    logic [CW-1:0] bank_len   [2];
    logic [1:0]    bank_write, bank_close, bank_start, bank_done;

    logic          wsel, rsel;
    logic          accept, close_blk;
    logic [CW-1:0] issued, recvd, len_hold;
    logic          rd_valid;
    logic [DW-1:0] rd_residual;
    logic [CW-1:0] rd_count, rd_len;

    drain_state_t  drain_q, drain_d;
    logic          start_blk, done_blk, drain_en, out_valid;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bank_state_tracker u_tracker (
            .clk   (iClock),
            .rst_n (iReset),
            .write (bank_write[b]),
            .close (bank_close[b]),
            .start (bank_start[b]),
            .done  (bank_done[b]),
            .state (bank_state[b]),
            .count (bank_count[b]),
            .len   (bank_len[b])
        );
    end

    // A block closes on iLast or when the DEPTH-th residual lands.
    assign oReady       = (bank_state[wsel] == BANK_EMPTY) || (bank_state[wsel] == BANK_FILLING);
    assign accept       = iValid && oReady;
    assign close_blk    = accept && (iLast || (bank_count[wsel] == CW'(DEPTH - 1)));
    assign oBufValid    = accept ? bank_mask(wsel) : 2'b00;
    assign oBufResidual = iResidual;
    assign bank_write   = oBufValid;
    assign bank_close   = close_blk ? bank_mask(wsel) : 2'b00;

    assign rd_valid    = rsel ? iBufValid1 : iBufValid0;
    assign rd_residual = rsel ? iBufResidual1 : iBufResidual0;
    assign rd_count    = rsel ? iBufCount1 : iBufCount0;
    assign rd_len      = bank_len[rsel];

    always_comb begin
        drain_d   = drain_q;
        start_blk = 1'b0;
        done_blk  = 1'b0;
        drain_en  = 1'b0;
        out_valid = 1'b0;
        case (drain_q)
            DRN_IDLE: begin
                if (bank_state[rsel] == BANK_FULL) drain_d = DRN_START;
            end
            DRN_START: begin
                start_blk = 1'b1;
                drain_d   = DRN_DRAIN;
            end
            DRN_DRAIN: begin
                // The bank answers one cycle after each enable, so at most one
                // residual is still in flight when iDownReady drops.
                drain_en  = iDownReady && (issued < rd_len);
                out_valid = rd_valid;
                if (rd_valid && (recvd == rd_len - 1'b1)) begin
                    done_blk = 1'b1;
                    drain_d  = DRN_IDLE;
                end
            end
            default: drain_d = DRN_IDLE;
        endcase
    end

    assign bank_start  = start_blk ? bank_mask(rsel) : 2'b00;
    assign bank_done   = done_blk ? bank_mask(rsel) : 2'b00;
    assign oBufEnable  = drain_en ? bank_mask(rsel) : 2'b00;
    assign oValid      = out_valid;
    assign oResidual   = out_valid ? rd_residual : '0;
    assign oBlockStart = start_blk;
    assign oBlockDone  = done_blk;
    assign oBlockLen   = start_blk ? rd_len : len_hold;
    assign oDrainState = drain_q;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            drain_q   <= DRN_IDLE;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            issued    <= '0;
            recvd     <= '0;
            len_hold  <= '0;
            oOverflow <= 1'b0;
            oError    <= 1'b0;
        end else begin
            drain_q <= drain_d;
            if (close_blk) wsel <= ~wsel;
            if (done_blk)  rsel <= ~rsel;
            if (start_blk) begin
                issued   <= '0;
                recvd    <= '0;
                len_hold <= rd_len;
            end else begin
                if (drain_en)  issued <= issued + 1'b1;
                if (out_valid) recvd  <= recvd + 1'b1;
            end
            if (iValid && !oReady)            oOverflow <= 1'b1;
            if (done_blk && (rd_count != '0)) oError    <= 1'b1;
        end
    end

endmodule

// File: doc/residual_buffer_ctrl.md
Name: residual_buffer_ctrl

Overview:
- Ping-pong scheduler for two ResidualBuffer banks in the FLAC encoder, sitting between the LPC residual generator and the Rice encoder.
- Steers incoming residuals into the filling bank while the other bank drains.
- Sequences each drain as a framed block: start pulse with length, one residual per enable, done pulse.
- Flags dropped input and bank/controller count mismatches.

Parameters:
DEPTH, 16, max residuals per block per bank (2..31)
CW, 5, count width; must hold DEPTH
DW, 16, signed residual width

Ports:
iClock  in  1  system clock, rising edge
iReset  in  1  asynchronous, active-low reset
iValid  in  1  upstream residual valid
iResidual  in  DW  upstream residual
iLast  in  1  qualifies iValid; last residual of block
oReady  out  1  upstream may assert iValid
oBufValid  out  2  per-bank iValid (bit0 = bank0)
oBufResidual  out  DW  iResidual forwarded to both banks
oBufEnable  out  2  per-bank oEnable
iBufResidual0/1  in  DW  bank oResidual
iBufValid0/1  in  1  bank oValid
iBufCount0/1  in  CW  bank counter
iDownReady  in  1  downstream stop-next control
oResidual  out  DW  drained residual (muxed)
oValid  out  1  drained residual valid
oBlockStart  out  1  one-cycle pulse before a drain
oBlockLen  out  CW  block length; valid with oBlockStart, held until next start
oBlockDone  out  1  one-cycle pulse on the last drained residual
oOverflow  out  1  sticky: residual dropped
oError  out  1  sticky: bank count nonzero at done

Behaviour:
- Reset values (iReset low, async):
  - banks EMPTY; wsel=0, rsel=0; counts 0; drain FSM IDLE.
  - All outputs 0, except oReady=1.
  - Banks share the system reset.
- Bank state, per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - oReady = bank[wsel] is EMPTY or FILLING (combinational).
  - On iValid&&oReady:
    - oBufValid[wsel]=1 (combinational).
    - wcnt++.
    - bank -> FILLING.
  - If iLast, or wcnt==DEPTH-1:
    - len[wsel] = wcnt+1.
    - bank -> FULL; wcnt=0; wsel toggles next cycle.
  - A DEPTH-th residual without iLast closes the block. The next residual opens a new block in the other bank.
- Overflow: iValid while !oReady -> residual dropped, oOverflow=1 until reset. No bank is written.
- Drain FSM, states IDLE, START, DRAIN:
  - IDLE: bank[rsel]==FULL -> START.
  - START (1 cycle):
    - oBlockStart=1, oBlockLen=len[rsel].
    - bank -> DRAINING; issued=0; recvd=0.
    - -> DRAIN.
  - DRAIN:
    - oBufEnable[rsel] = iDownReady && issued<len; issued++ on each enable.
    - The bank returns data 1 cycle after enable.
    - oValid = iBufValid[rsel]; oResidual = iBufResidual[rsel]; recvd++ on each.
    - When the recvd==len-1 residual arrives:
      - oBlockDone=1 in the same cycle as that oValid.
      - oError|=(iBufCount[rsel]!=0) on the following cycle.
      - bank -> EMPTY; rsel toggles; -> IDLE.
- Stall: dropping iDownReady stops new enables. Downstream must accept one in-flight residual (1-entry skid).
- Concurrency:
  - Write into one bank and drain the other in the same cycle is allowed.
  - A bank reaching FULL while the FSM is in IDLE -> START on the next cycle.
- Minimum inter-block gap on the drain side: 1 cycle (IDLE) + 1 (START).
- Reset mid-operation: all in-progress blocks are discarded; no done pulse is issued.

Decomposition:
- Shared package (flac_enc_pkg):
  - DEPTH, CW, DW.
  - Bank-state encoding: EMPTY=0, FILLING=1, FULL=2, DRAINING=3.
  - Drain FSM encoding.
- Sub-module: bank_state_tracker, one instance per bank. Holds the state, fill counter and latched len, and updates them on write/close/start/done strobes.
- The top level holds wsel/rsel, the drain FSM, the issued/recvd counters and the output mux.

Test Plan:
1. Reset, then 12 residuals (20, -123, 31, 100, 16, 32, 64, -123, 31, 100, 16, 32) with iLast on the 12th, iDownReady=1:
   - oBlockStart with oBlockLen=12.
   - 12 oValid in the same order.
   - oBlockDone on the 12th; oError=0.
2. 16 residuals with no iLast, then 5 with iLast:
   - Bank0 closes at 16, len=16; bank1 gets 5.
   - Two framed blocks in order: 16 then 5.
   - Bank1 writes overlap bank0 drain.
3. During drain of an 8-residual block, hold iDownReady=0 for 4 cycles after the 3rd output:
   - At most 1 further oValid during the stall.
   - Total 8 outputs, none lost or duplicated.
4. Both banks FULL with iDownReady=0, then push 1 more residual:
   - oReady=0; oOverflow=1 and stays set.
   - Both blocks drain intact once iDownReady=1.
5. Pull iReset low mid-drain (after 4 of 10 outputs):
   - All outputs 0 immediately; oReady=1.
   - A fresh 3-residual block afterwards drains with oBlockLen=3, starting from bank0.
6. Bank model that leaves counter=1 at done:
   - oError=1 one cycle after oBlockDone.
